// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged target buffer with 2-bit saturating
// counters, a mispredict detector and saturating performance counters.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_F,
    output logic            PredTaken_F,
    output logic [XLEN-1:0] PredTarget_F,
    input  logic            Update_C,
    input  logic [XLEN-1:0] PC_C,
    input  logic            Taken_C,
    input  logic [XLEN-1:0] Target_C,
    input  logic            PredTaken_C,
    input  logic [XLEN-1:0] PredTarget_C,
    output logic            Mispredict_C,
    output logic [15:0]     BranchCount,
    output logic [15:0]     MispredictCount
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam int unsigned CNT_W = 16;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] c_idx;
    logic [TAG_W-1:0] c_tag;
    logic             c_hit;
    logic [1:0]       c_ctr_next;

    // Word-aligned PC bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC_F[1:0], PC_C[1:0]};

    assign f_idx = PC_F[IDX_W+1:2];
    assign f_tag = PC_F[XLEN-1:IDX_W+2];
    assign c_idx = PC_C[IDX_W+1:2];
    assign c_tag = PC_C[XLEN-1:IDX_W+2];

    // Fetch lookup: reads stored state only, so a same-cycle update is not bypassed.
    always_comb begin
        f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        PredTaken_F  = f_hit && ctr_q[f_idx][1];
        PredTarget_F = PredTaken_F ? target_q[f_idx] : '0;
    end

    // Resolve-side hit detection and saturating counter step.
    always_comb begin
        c_hit      = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
        c_ctr_next = ctr_q[c_idx];
        if (Taken_C) begin
            if (ctr_q[c_idx] != 2'b11) c_ctr_next = ctr_q[c_idx] + 2'b01;
        end else begin
            if (ctr_q[c_idx] != 2'b00) c_ctr_next = ctr_q[c_idx] - 2'b01;
        end
    end

    // Wrong direction, or right "taken" direction with the wrong target.
    always_comb begin
        Mispredict_C = Update_C &&
                       ((PredTaken_C != Taken_C) ||
                        (Taken_C && PredTaken_C && (PredTarget_C != Target_C)));
    end

    // Predictor table: train on hit, allocate on taken miss, ignore not-taken miss.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q  <= '0;
            tag_q    <= '{default: '0};
            target_q <= '{default: '0};
            ctr_q    <= '{default: 2'b01};
        end else if (Update_C) begin
            if (c_hit) begin
                ctr_q[c_idx] <= c_ctr_next;
                if (Taken_C) target_q[c_idx] <= Target_C;
            end else if (Taken_C) begin
                valid_q[c_idx]  <= 1'b1;
                tag_q[c_idx]    <= c_tag;
                target_q[c_idx] <= Target_C;
                ctr_q[c_idx]    <= 2'b10;
            end
        end
    end

    // Saturating branch and mispredict counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else begin
            if (Update_C && (BranchCount != {CNT_W{1'b1}}))
                BranchCount <= BranchCount + CNT_W'(1);
            if (Mispredict_C && (MispredictCount != {CNT_W{1'b1}}))
                MispredictCount <= MispredictCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=16, XLEN=32).
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] PC_F;
    logic        PredTaken_F;
    logic [31:0] PredTarget_F;
    logic        Update_C;
    logic [31:0] PC_C;
    logic        Taken_C;
    logic [31:0] Target_C;
    logic        PredTaken_C;
    logic [31:0] PredTarget_C;
    logic        Mispredict_C;
    logic [15:0] BranchCount;
    logic [15:0] MispredictCount;

    int errors = 0;
    int checks = 0;

    branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .PC_F(PC_F), .PredTaken_F(PredTaken_F), .PredTarget_F(PredTarget_F),
        .Update_C(Update_C), .PC_C(PC_C), .Taken_C(Taken_C), .Target_C(Target_C),
        .PredTaken_C(PredTaken_C), .PredTarget_C(PredTarget_C),
        .Mispredict_C(Mispredict_C),
        .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        upd;
        logic [31:0] pc_c;
        logic        taken;
        logic [31:0] tgt;
        logic        ptaken;
        logic [31:0] ptgt;
        logic        exp_mis;
        logic [31:0] look_pc;
        logic        exp_pt;
        logic [31:0] exp_ptgt;
        int          exp_bc;
        int          exp_mc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_update(input logic upd, input logic [31:0] pc, input logic tk,
                                input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
        Update_C     = upd;
        PC_C         = pc;
        Taken_C      = tk;
        Target_C     = tg;
        PredTaken_C  = ptk;
        PredTarget_C = ptg;
    endtask

    task automatic check_lookup(input string name, input logic [31:0] pc,
                                input logic exp_pt, input logic [31:0] exp_tgt);
        PC_F = pc;
        #1;
        check({name, ".taken"}, 32'(PredTaken_F), 32'(exp_pt));
        check({name, ".target"}, PredTarget_F, exp_tgt);
    endtask

    initial begin
        // upd pc_c taken tgt ptaken ptgt | exp_mis look_pc exp_pt exp_ptgt bc mc
        vecs[0]  = '{1'b1, 32'h100, 1'b1, 32'h80,  1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h80,  1,  1};
        vecs[1]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h100, 1'b0, 32'h0,   2,  2};
        vecs[2]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,   3,  2};
        vecs[3]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,   4,  2};
        vecs[4]  = '{1'b1, 32'h100, 1'b1, 32'h90,  1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   5,  3};
        vecs[5]  = '{1'b1, 32'h100, 1'b1, 32'h90,  1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h90,  6,  4};
        vecs[6]  = '{1'b1, 32'h100, 1'b1, 32'h90,  1'b1, 32'h90,  1'b0, 32'h100, 1'b1, 32'h90,  7,  4};
        vecs[7]  = '{1'b1, 32'h100, 1'b1, 32'hA0,  1'b1, 32'h90,  1'b1, 32'h100, 1'b1, 32'hA0,  8,  5};
        vecs[8]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'hA0,  1'b1, 32'h100, 1'b1, 32'hA0,  9,  6};
        vecs[9]  = '{1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   10, 7};
        vecs[10] = '{1'b0, 32'h140, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h140, 1'b1, 32'h200, 10, 7};
        vecs[11] = '{1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h140, 1'b1, 32'h200, 11, 7};
        vecs[12] = '{1'b1, 32'h208, 1'b1, 32'h40,  1'b0, 32'h0,   1'b1, 32'h20C, 1'b0, 32'h0,   12, 8};
        vecs[13] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h40,  12, 8};

        reset = 1'b0;
        PC_F  = 32'h100;
        drive_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset state
        check_lookup("reset_lookup", 32'h100, 1'b0, 32'h0);
        check("reset_bc", 32'(BranchCount), 32'd0);
        check("reset_mc", 32'(MispredictCount), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive_update(vecs[i].upd, vecs[i].pc_c, vecs[i].taken, vecs[i].tgt,
                         vecs[i].ptaken, vecs[i].ptgt);
            #1;
            check($sformatf("v%0d.mispredict", i), 32'(Mispredict_C), 32'(vecs[i].exp_mis));
            @(negedge clk);
            drive_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            check_lookup($sformatf("v%0d.lookup", i), vecs[i].look_pc, vecs[i].exp_pt, vecs[i].exp_ptgt);
            check($sformatf("v%0d.bc", i), 32'(BranchCount), 32'(vecs[i].exp_bc));
            check($sformatf("v%0d.mc", i), 32'(MispredictCount), 32'(vecs[i].exp_mc));
        end

        // Same-cycle lookup and allocating update return pre-update contents
        @(negedge clk);
        drive_update(1'b1, 32'h104, 1'b1, 32'h400, 1'b0, 32'h0);
        check_lookup("same_cycle_before", 32'h104, 1'b0, 32'h0);
        @(negedge clk);
        drive_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_lookup("same_cycle_after", 32'h104, 1'b1, 32'h400);
        check("same_cycle_bc", 32'(BranchCount), 32'd13);
        check("same_cycle_mc", 32'(MispredictCount), 32'd9);

        // Counter saturation under a long mispredicting stream
        @(negedge clk);
        drive_update(1'b1, 32'h600, 1'b1, 32'h10, 1'b0, 32'h0);
        for (int i = 0; i < 65540; i++) @(negedge clk);
        check("sat_bc", 32'(BranchCount), 32'h0000FFFF);
        check("sat_mc", 32'(MispredictCount), 32'h0000FFFF);

        // Reset mid-stream: concurrent update discarded, mispredict still combinational
        drive_update(1'b1, 32'h500, 1'b1, 32'h44, 1'b0, 32'h0);
        reset = 1'b0;
        #1;
        check("reset_mispredict_comb", 32'(Mispredict_C), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        drive_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("post_reset_bc", 32'(BranchCount), 32'd0);
        check("post_reset_mc", 32'(MispredictCount), 32'd0);
        check_lookup("post_reset_100", 32'h100, 1'b0, 32'h0);
        check_lookup("post_reset_140", 32'h140, 1'b0, 32'h0);
        check_lookup("post_reset_104", 32'h104, 1'b0, 32'h0);
        check_lookup("post_reset_208", 32'h208, 1'b0, 32'h0);
        check_lookup("post_reset_600", 32'h600, 1'b0, 32'h0);
        check_lookup("post_reset_500", 32'h500, 1'b0, 32'h0);

        // Not-taken update on a fresh entry's counter (reset value 01) does not allocate
        @(negedge clk);
        drive_update(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        drive_update(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_lookup("nt_miss_no_alloc", 32'h100, 1'b0, 32'h0);
        check("nt_miss_bc", 32'(BranchCount), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, 16, number of direct-mapped predictor entries (power of two, 4..64).
REQ-002 Parameter: XLEN, 32, PC and target width.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 Port: PC_F  input  XLEN  fetch-stage PC to be predicted.
REQ-006 Port: PredTaken_F  output  1  prediction for PC_F: 1 = redirect fetch to PredTarget_F.
REQ-007 Port: PredTarget_F  output  XLEN  predicted target for PC_F; 0 when PredTaken_F = 0.
REQ-008 Port: Update_C  input  1  a conditional branch resolved in the computational stage this cycle.
REQ-009 Port: PC_C  input  XLEN  PC of the resolving branch.
REQ-010 Port: Taken_C  input  1  resolved outcome (1 = PC source resolved to Branch_C, 0 = PCp4_I).
REQ-011 Port: Target_C  input  XLEN  resolved branch target.
REQ-012 Port: PredTaken_C, PredTarget_C  input  1, XLEN  prediction made for this branch, carried down the pipeline.
REQ-013 Port: Mispredict_C  output  1  combinational: prediction for the resolving branch was wrong; fetch must be redirected.
REQ-014 Port: BranchCount, MispredictCount  output  16 each  saturating performance counters.

Function
REQ-015 Index = PC[log2(ENTRIES)+1:2]; tag = PC[XLEN-1:log2(ENTRIES)+2]; each entry holds valid, tag, XLEN-bit target and a 2-bit saturating counter.
REQ-016 Lookup is combinational on PC_F: hit = entry valid and tag match; PredTaken_F = hit AND counter[1]; PredTarget_F = entry target when PredTaken_F = 1, else 0.
REQ-017 Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
REQ-018 On Update_C = 1 with tag hit at PC_C index: counter increments (saturating at 11) if Taken_C = 1, else decrements (saturating at 00); target written with Target_C when Taken_C = 1.
REQ-019 On Update_C = 1 with miss and Taken_C = 1: entry allocated (replaces existing contents): valid = 1, tag from PC_C, target = Target_C, counter = 10.
REQ-020 On Update_C = 1 with miss and Taken_C = 0: no entry change.
REQ-021 Update latency: one cycle; new entry contents visible to lookup on the cycle after the update edge.
REQ-022 Same-cycle lookup and update of the same index: lookup returns pre-update contents (no bypass).
REQ-023 Mispredict_C = Update_C AND ((PredTaken_C != Taken_C) OR (Taken_C AND PredTaken_C AND PredTarget_C != Target_C)); 0 whenever Update_C = 0.
REQ-024 BranchCount increments by 1 on every cycle with Update_C = 1; MispredictCount increments on every cycle with Mispredict_C = 1; both hold at 16'hFFFF.
REQ-025 Update_C inputs other than Update_C itself are ignored when Update_C = 0.

Reset
REQ-026 While reset = 0 at a rising edge: all valid bits cleared, all counters set to 01, all targets cleared, BranchCount = MispredictCount = 0; any concurrent Update_C is discarded.
REQ-027 After reset: PredTaken_F = 0 and PredTarget_F = 0 for every PC_F until an allocating update occurs; Mispredict_C remains combinational and is not gated by reset.

Verification
REQ-028 Reset, then PC_F = 0x100 -> PredTaken_F = 0, PredTarget_F = 0, both counters 0.
REQ-029 Update_C=1, PC_C=0x100, Taken_C=1, Target_C=0x80, PredTaken_C=0 -> Mispredict_C=1 that cycle; next cycle PC_F=0x100 gives PredTaken_F=1, PredTarget_F=0x80; BranchCount=1, MispredictCount=1.
REQ-030 Continuing: two not-taken updates at 0x100 -> counter 10->01->00; PredTaken_F=0 after the first; a third not-taken update leaves counter at 00.
REQ-031 Aliasing: allocate 0x100 taken, then allocate 0x140 (same index for ENTRIES=16) taken to 0x200 -> PC_F=0x100 misses (PredTaken_F=0); PC_F=0x140 predicts 0x200.
REQ-032 Same-cycle: PC_F=PC_C=0x104, first allocating update -> PredTaken_F=0 that cycle, 1 the next.
REQ-033 Drive 65 540 updates with mispredicts -> both counters hold at 16'hFFFF; assert reset=0 mid-stream -> both 0 and all lookups miss the next cycle.
